// File: rtl/brentkung_sub_pipe.sv
// Two-stage valid/ready Brent-Kung subtractor: D = A - B - Bin.
// Ports: clk, rst_n, in_valid/in_ready, A, B, Bin, out_valid/out_ready, D, Bout, Ovf, Zero.
module brentkung_sub_pipe #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] D,
  output logic         Bout,
  output logic         Ovf,
  output logic         Zero
);

  localparam int L = $clog2(N);

  // Upward sweep: node i with (i+1) a multiple of 2^l
  // absorbs the group ending 2^(l-1) below it.
  function automatic logic [2*N-1:0] bk_up(
    input logic [N-1:0] p,
    input logic [N-1:0] g
  );
    logic [N-1:0] pp;
    logic [N-1:0] gg;
    int d;
    pp = p;
    gg = g;
    for (int l = 1; l <= L; l++) begin
      d = 1 << (l - 1);
      for (int i = 0; i < N; i++) begin
        if (((i + 1) % (2 * d)) == 0) begin
          gg[i] = gg[i] | (pp[i] & gg[i-d]);
          pp[i] = pp[i] & pp[i-d];
        end
      end
    end
    return {pp, gg};
  endfunction

  // Downward sweep: nodes at odd multiples of 2^(l-1)
  // pick up the full prefix just below their group.
  function automatic logic [N-1:0] bk_dn(
    input logic [N-1:0] p,
    input logic [N-1:0] g
  );
    logic [N-1:0] gg;
    int d;
    gg = g;
    for (int l = L - 1; l >= 1; l--) begin
      d = 1 << (l - 1);
      for (int i = 0; i < N; i++) begin
        if (i >= 2 * d && ((i + 1) % (2 * d)) == d) begin
          gg[i] = gg[i] | (p[i] & gg[i-d]);
        end
      end
    end
    return gg;
  endfunction

  // Stage 1 combinational
  logic [N-1:0]   w_p;
  logic [N-1:0]   w_g0;
  logic [N-1:0]   w_g;
  logic           w_cin;
  logic [2*N-1:0] w_up;

  assign w_p   = A ^ ~B;
  assign w_g0  = A & ~B;
  assign w_cin = ~Bin;

  // Carry-in is folded into bit 0 so group G
  // terms are true carries out of each bit.
  always_comb begin
    w_g    = w_g0;
    w_g[0] = w_g0[0] | (w_p[0] & w_cin);
  end

  assign w_up = bk_up(w_p, w_g);

  // Stage 1 registers
  logic         r_s1_valid;
  logic [N-1:0] r_gp;
  logic [N-1:0] r_gg;
  logic [N-1:0] r_p;
  logic         r_cin;
  logic         r_a_msb;
  logic         r_b_msb;

  // Stage 2 registers
  logic         r_out_valid;
  logic [N-1:0] r_d;
  logic         r_bout;
  logic         r_ovf;
  logic         r_zero;

  logic w_s2_ready;
  logic w_fire;

  assign w_s2_ready = !r_out_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_ready;
  assign w_fire     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_fire) begin
      r_gp    <= w_up[2*N-1:N];
      r_gg    <= w_up[N-1:0];
      r_p     <= w_p;
      r_cin   <= w_cin;
      r_a_msb <= A[N-1];
      r_b_msb <= B[N-1];
    end
  end

  // Stage 2 combinational
  logic [N-1:0] w_c;
  logic [N-1:0] w_d;
  logic         w_ovf;

  assign w_c   = bk_dn(r_gp, r_gg);
  assign w_d   = r_p ^ {w_c[N-2:0], r_cin};
  assign w_ovf = (r_a_msb != r_b_msb) &&
                 (w_d[N-1] != r_a_msb);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_d         <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_s2_ready) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_d    <= w_d;
        r_bout <= ~w_c[N-1];
        r_ovf  <= w_ovf;
        r_zero <= ~|w_d;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign D         = r_d;
  assign Bout      = r_bout;
  assign Ovf       = r_ovf;
  assign Zero      = r_zero;

endmodule

// File: doc/brentkung_sub_pipe.md
BRENTKUNG_SUB_PIPE -- requirements
Module: brentkung_sub_pipe

Interface
REQ-001 SHALL have parameter N, default 16: operand width; legal values are powers of two, N >= 4.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand set A/B/Bin is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-006 SHALL have port A, input, N bits: minuend.
REQ-007 SHALL have port B, input, N bits: subtrahend.
REQ-008 SHALL have port Bin, input, 1 bit: borrow-in.
REQ-009 SHALL have port out_valid, output, 1 bit: the result and flags are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-011 SHALL have port D, output, N bits: difference A - B - Bin, modulo 2^N.
REQ-012 SHALL have port Bout, output, 1 bit: borrow-out, 1 iff unsigned A < B + Bin.
REQ-013 SHALL have port Ovf, output, 1 bit: two's-complement overflow.
REQ-014 SHALL have port Zero, output, 1 bit: 1 iff D == 0.

Function
REQ-015 SHALL compute D as A + ~B + ~Bin, with carry-in = ~Bin and Bout = ~carry-out.
REQ-016 SHALL generate carries with a Brent-Kung prefix network on P = A ^ ~B and G = A & ~B.
- Upward reduction: log2(N) levels.
- Downward distribution follows.
- No ripple or behavioural "-" operator on the N-bit datapath.
REQ-017 SHALL be a 2-stage pipeline.
- Stage 1 registers the upward-reduction group P/G terms, bitwise P, and carry-in.
- Stage 2 performs distribution and the sum XOR, then registers D and the flags.
REQ-018 SHALL transfer an input when in_valid && in_ready is high at a clock edge; out_valid SHALL rise exactly 2 cycles after the transfer when no stall occurs.
REQ-019 SHALL sustain throughput of one operation per cycle while out_ready is held high.
REQ-020 SHALL use these ready terms:
- s2_ready = !out_valid || out_ready.
- in_ready = !s1_valid || s2_ready.
- in_ready is combinational on out_ready; there is no combinational path from in_valid to in_ready.
REQ-021 SHALL hold D, Bout, Ovf, Zero and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL keep stage-1 contents unchanged while stage 1 is valid and s2_ready = 0.
REQ-023 SHALL, when the output is consumed and a new operand set is accepted on the same edge, advance both stages with no bubble and no lost or duplicated result.
REQ-024 SHALL deliver results in acceptance order.
REQ-025 SHALL compute Ovf = (A[N-1] != B[N-1]) && (D[N-1] != A[N-1]), using the A and B of the same operation.
REQ-026 SHALL leave D and the flags don't-care while out_valid = 0; the bench SHALL NOT check them then.
REQ-027 SHALL ignore A, B and Bin in any cycle where in_valid && in_ready is low.

Reset
REQ-028 SHALL, on a clock edge with rst_n = 0, clear s1_valid and out_valid to 0, and clear D, Bout, Ovf and Zero to 0.
REQ-029 SHALL drive in_ready = 1 in the first cycle after reset release.
REQ-030 SHALL discard any in-flight operations when reset asserts mid-operation; no result from them SHALL appear afterwards.
REQ-031 SHALL NOT accept input on an edge where rst_n = 0.

Verification (N = 16)
REQ-032 SHALL cover the basic case:
- Stimulus: A=0x0005, B=0x0003, Bin=0, out_ready=1.
- Response: D=0x0002, Bout=0, Ovf=0, Zero=0; out_valid high exactly 2 cycles after acceptance.
REQ-033 SHALL cover the borrow and overflow cases:
- A=0x0000, B=0x0001, Bin=0 -> D=0xFFFF, Bout=1, Ovf=0.
- A=0x8000, B=0x0001, Bin=0 -> D=0x7FFF, Bout=0, Ovf=1.
REQ-034 SHALL cover the zero and borrow-in cases:
- A=0x1234, B=0x1233, Bin=1 -> D=0x0000, Zero=1, Bout=0.
- A=0x0000, B=0xFFFF, Bin=1 -> D=0x0000, Bout=1, Zero=1.
REQ-035 SHALL cover backpressure:
- Stimulus: issue 4 back-to-back operands with out_ready=0 for 4 cycles, then 1.
- Response: in_ready drops after 2 acceptances; output held stable; all 4 results emerge in order with no gaps once out_ready=1.
REQ-036 SHALL cover reset mid-operation:
- Stimulus: rst_n=0 for 1 cycle with both stages valid.
- Response: out_valid=0 and in_ready=1 the next cycle; no stale result ever appears.
REQ-037 SHALL run a random regression of >= 10k operations with random in_valid/out_ready, compared against the reference A - B - Bin for every N in {4, 16, 32}.
